control_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32I core: fetch -> decode -> execute -> mem -> writeback.

---
 rtl/ctrl_pkg.sv | 52 +++++
 rtl/control_fsm_op_class.sv | 25 ++
 rtl/control_fsm.sv | 148 ++++++++++++++
 tb/tb_control_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer: states, opcodes,
// PC/writeback mux selects and the opcode-class bundle.
package ctrl_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [SEL_W-1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [SEL_W-1:0] PC_SEL_IMM   = 2'd1;
  localparam logic [SEL_W-1:0] PC_SEL_ALU   = 2'd2;

  localparam logic [SEL_W-1:0] WB_SEL_ALU = 2'd0;
  localparam logic [SEL_W-1:0] WB_SEL_MEM = 2'd1;
  localparam logic [SEL_W-1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [SEL_W-1:0] WB_SEL_IMM = 2'd3;

  // One-hot instruction class; illegal covers every unsupported opcode.
  typedef struct packed {
    logic is_op;
    logic is_imm;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_lui;
    logic is_auipc;
    logic illegal;
  } op_cls_t;

endpackage

// File: rtl/control_fsm_op_class.sv
// Combinational RV32I opcode classifier feeding the control sequencer.
module op_class
  import ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_cls_t             cls
);

  always_comb begin
    cls = '0;
    unique case (opcode)
      OPC_OP:     cls.is_op     = 1'b1;
      OPC_OP_IMM: cls.is_imm    = 1'b1;
      OPC_LOAD:   cls.is_load   = 1'b1;
      OPC_STORE:  cls.is_store  = 1'b1;
      OPC_BRANCH: cls.is_branch = 1'b1;
      OPC_JAL:    cls.is_jal    = 1'b1;
      OPC_JALR:   cls.is_jalr   = 1'b1;
      OPC_LUI:    cls.is_lui    = 1'b1;
      OPC_AUIPC:  cls.is_auipc  = 1'b1;
      default:    cls.illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I sequencer: fetch -> decode -> execute -> mem -> writeback, with a
// sticky trap on illegal opcodes or an optional memory-wait timeout.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct3,
  input  logic                branch_taken,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                ir_we,
  output logic                alu_src_a,
  output logic                alu_src_b,
  output logic                pc_we,
  output logic [SEL_W-1:0]    pc_sel,
  output logic                reg_we,
  output logic [SEL_W-1:0]    wb_sel,
  output logic                trap,
  output logic [STATE_W-1:0]  state
);

  localparam bit TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'((MEM_TIMEOUT == 0) ? 32'd0 : MEM_TIMEOUT - 32'd1);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  op_cls_t              cls;
  logic                 timeout_hit;
  logic                 unused_funct3;

  // funct3 only travels to the datapath; sequencing never looks at it.
  assign unused_funct3 = ^funct3;
  assign state         = state_q;

  op_class u_op_class (
    .opcode (opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and strobes; the wait counter only survives while a request keeps waiting.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_PLUS4;
    reg_we       = 1'b0;
    wb_sel       = WB_SEL_ALU;
    trap         = 1'b0;
    timeout_hit  = TO_EN && (cnt_q == TO_LAST);

    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end

      ST_DECODE: state_d = cls.illegal ? ST_TRAP : ST_EXEC;

      ST_EXEC: begin
        alu_src_a = cls.is_auipc | cls.is_jal;
        alu_src_b = ~(cls.is_op | cls.is_branch);
        if (cls.is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
          state_d = ST_FETCH;
        end else if (cls.is_load | cls.is_store) begin
          state_d = ST_MEM;
        end else if (cls.is_op | cls.is_imm | cls.is_jal | cls.is_jalr |
                     cls.is_lui | cls.is_auipc) begin
          state_d = ST_WB;
        end else begin
          // Opcode changed under us after decode: treat as a fault.
          state_d = ST_TRAP;
        end
      end

      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = cls.is_store;
        if (mem_ready) begin
          if (cls.is_store) begin
            pc_we   = 1'b1;
            pc_sel  = PC_SEL_PLUS4;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout_hit) begin
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end

      ST_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        if (cls.is_load)                    wb_sel = WB_SEL_MEM;
        else if (cls.is_jal | cls.is_jalr)  wb_sel = WB_SEL_PC4;
        else if (cls.is_lui)                wb_sel = WB_SEL_IMM;
        else                                wb_sel = WB_SEL_ALU;
        if (cls.is_jal)       pc_sel = PC_SEL_IMM;
        else if (cls.is_jalr) pc_sel = PC_SEL_ALU;
        else                  pc_sel = PC_SEL_PLUS4;
        state_d = ST_FETCH;
      end

      ST_TRAP: trap = 1'b1;

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Randomized scoreboard bench for control_fsm: one instance without a memory timeout and
// one with MEM_TIMEOUT=4 share the same stimulus; a monitor checks every cycle's outputs.
module tb_control_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       trap;
    logic [2:0] state;
  } obs_t;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_SYSTEM = 7'b1110011;
  localparam logic [6:0] LEGAL [9] = '{T_OP, T_OPIMM, T_LOAD, T_STORE, T_BRANCH,
                                       T_JAL, T_JALR, T_LUI, T_AUIPC};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;

  logic [1:0] mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, alu_src_a_o, alu_src_b_o;
  logic [1:0] pc_we_o, reg_we_o, trap_o;
  logic [1:0] pc_sel_o [2];
  logic [1:0] wb_sel_o [2];
  logic [2:0] state_o  [2];

  obs_t exp0_q [$];
  obs_t exp1_q [$];
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;
  bit   to_tripped = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    control_fsm #(
      .MEM_TIMEOUT ((g == 0) ? 0 : 4),
      .TIMEOUT_W   (8)
    ) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .opcode       (opcode),
      .funct3       (funct3),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req_o[g]),
      .mem_we       (mem_we_o[g]),
      .mem_addr_sel (mem_addr_sel_o[g]),
      .ir_we        (ir_we_o[g]),
      .alu_src_a    (alu_src_a_o[g]),
      .alu_src_b    (alu_src_b_o[g]),
      .pc_we        (pc_we_o[g]),
      .pc_sel       (pc_sel_o[g]),
      .reg_we       (reg_we_o[g]),
      .wb_sel       (wb_sel_o[g]),
      .trap         (trap_o[g]),
      .state        (state_o[g])
    );
  end

  function automatic obs_t actual(input bit k);
    return {mem_req_o[k], mem_we_o[k], mem_addr_sel_o[k], ir_we_o[k], alu_src_a_o[k],
            alu_src_b_o[k], pc_we_o[k], pc_sel_o[k], reg_we_o[k], wb_sel_o[k],
            trap_o[k], state_o[k]};
  endfunction

  function automatic obs_t trapv();
    obs_t e = '0;
    e.trap  = 1'b1;
    e.state = 3'd6;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (LEGAL[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input bit k, input obs_t e);
    obs_t a;
    a = actual(k);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL outputs_dut%0d t=%0t got=%h (state %0d) want=%h (state %0d)",
               k, $time, a, a.state, e, e.state);
    end
  endtask

  // Monitor: compares whatever the DUTs present against the oldest expectation.
  always @(negedge clk) begin
    if (exp0_q.size() > 0) check(1'b0, exp0_q.pop_front());
    if (exp1_q.size() > 0) check(1'b1, exp1_q.pop_front());
    if (done) begin
      total++;
      if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
        bad++;
        $display("FAIL queue_drain got=%0d/%0d left want=0", exp0_q.size(), exp1_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic rn, input logic mr, input logic bt, input logic [6:0] op,
                      input obs_t e0, input obs_t e1);
    @(posedge clk);
    #1;
    reset_n      = rn;
    mem_ready    = mr;
    branch_taken = bt;
    opcode       = op;
    funct3       = 3'($urandom);
    exp0_q.push_back(e0);
    exp1_q.push_back(e1);
  endtask

  // One running cycle; the timeout instance shows a trap once it has tripped.
  task automatic cyc(input logic mr, input logic bt, input logic [6:0] op, input obs_t e);
    step(1'b1, mr, bt, op, e, to_tripped ? trapv() : e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rb(), rb(), 7'($urandom), '0, '0);
    step(1'b1, rb(), rb(), 7'($urandom), '0, '0);
    to_tripped = 1'b0;
  endtask

  // nw unanswered cycles, then (optionally) the completing cycle.
  task automatic mem_phase(input logic [6:0] op, input int nw, input obs_t w, input obs_t d,
                           input bit complete);
    for (int i = 0; i < nw; i++) begin
      cyc(1'b0, rb(), op, w);
      if (i == 3) to_tripped = 1'b1;
    end
    if (complete) cyc(1'b1, rb(), op, d);
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic bt,
                           input bit abort);
    obs_t e, w;
    bit ld, st, br;
    ld = (op == T_LOAD);
    st = (op == T_STORE);
    br = (op == T_BRANCH);

    w = '0; w.state = 3'd1; w.mem_req = 1'b1;
    e = w;  e.ir_we = 1'b1;
    mem_phase(op, fw, w, e, 1'b1);

    e = '0; e.state = 3'd2;
    cyc(rb(), rb(), op, e);

    if (!is_legal(op)) begin
      for (int i = 0; i < 20; i++) step(1'b1, rb(), rb(), op, trapv(), trapv());
      do_reset(2);
      return;
    end

    e = '0; e.state = 3'd3;
    e.alu_src_a = (op == T_AUIPC) || (op == T_JAL);
    e.alu_src_b = !((op == T_OP) || br);
    if (br) begin
      e.pc_we  = 1'b1;
      e.pc_sel = bt ? 2'd1 : 2'd0;
    end
    cyc(rb(), bt, op, e);

    if (ld || st) begin
      w = '0; w.state = 3'd4; w.mem_req = 1'b1; w.mem_addr_sel = 1'b1; w.mem_we = st;
      e = w;
      if (st) e.pc_we = 1'b1;
      mem_phase(op, mw, w, e, !abort);
      if (abort) begin
        do_reset(2);
        return;
      end
    end

    if (!br && !st) begin
      e = '0; e.state = 3'd5; e.reg_we = 1'b1; e.pc_we = 1'b1;
      if (ld)                              e.wb_sel = 2'd1;
      else if (op == T_JAL || op == T_JALR) e.wb_sel = 2'd2;
      else if (op == T_LUI)                e.wb_sel = 2'd3;
      else                                 e.wb_sel = 2'd0;
      if (op == T_JAL)       e.pc_sel = 2'd1;
      else if (op == T_JALR) e.pc_sel = 2'd2;
      else                   e.pc_sel = 2'd0;
      cyc(rb(), rb(), op, e);
    end

    if (to_tripped) do_reset(1);
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
  endfunction

  initial begin
    logic [6:0] op;
    do_reset(3);
    run_instr(T_OP, 0, 0, 1'b0, 1'b0);
    run_instr(T_LOAD, 0, 3, 1'b0, 1'b0);
    run_instr(T_BRANCH, 0, 0, 1'b1, 1'b0);
    run_instr(T_BRANCH, 0, 0, 1'b0, 1'b0);
    run_instr(T_SYSTEM, 0, 0, 1'b0, 1'b0);
    run_instr(T_OP, 4, 0, 1'b0, 1'b0);
    run_instr(T_OP, 3, 0, 1'b0, 1'b0);
    run_instr(T_STORE, 1, 4, 1'b0, 1'b0);
    run_instr(T_STORE, 0, 2, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) run_instr(LEGAL[i], 0, 0, rb(), 1'b0);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        op = 7'($urandom);
        if (is_legal(op)) op = T_SYSTEM;
      end else begin
        op = LEGAL[$urandom_range(0, 8)];
      end
      run_instr(op, rand_wait(), rand_wait(), rb(), $urandom_range(0, 19) == 0);
    end
    @(posedge clk);
    #1;
    done = 1'b1;
  end

endmodule
